// File: rtl/param_counter_pkg.sv
// Shared encodings for the arithmetic-sequence step counter family.
// Mode, end-behaviour and direction constants used by the counter and its next-state logic.
package param_counter_pkg;

    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    localparam logic END_WRAP = 1'b0;
    localparam logic END_SAT  = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } dir_state_e;

endpackage

// File: rtl/step_count_next.sv
// Combinational successor logic for the step counter: next count, next direction and end event.
// Sums run one bit wider than the count so no intermediate value can wrap.
module step_count_next
    import param_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int STEP    = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 14
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             dir_i,
    input  logic [1:0]       c_i,
    input  logic             sat_mode_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             next_dir_o,
    output logic             end_event_o
);

    localparam int EW = WIDTH + 1;
    localparam logic [WIDTH:0] MIN_X  = EW'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X  = EW'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_X = (MAX_VAL > MIN_VAL) ? EW'(STEP) : EW'(1);
    // A single-point sequence reverses in place instead of stepping off the end.
    localparam logic [WIDTH:0] BOUNCE_DN_X = (MAX_VAL > MIN_VAL) ? EW'(MAX_VAL - STEP) : MAX_X;
    localparam logic [WIDTH:0] BOUNCE_UP_X = (MAX_VAL > MIN_VAL) ? EW'(MIN_VAL + STEP) : MIN_X;

    logic [WIDTH:0] count_x;
    logic [WIDTH:0] next_x;
    logic           at_max;
    logic           at_min;

    assign count_x      = {1'b0, count_i};
    assign at_max       = (count_x == MAX_X);
    assign at_min       = (count_x == MIN_X);
    assign next_count_o = WIDTH'(next_x);

    // Mode-dependent successor selection.
    always_comb begin
        next_x      = count_x;
        next_dir_o  = dir_i;
        end_event_o = 1'b0;
        case (c_i)
            MODE_UP: begin
                next_dir_o = DIR_UP;
                if (at_max) begin
                    end_event_o = 1'b1;
                    next_x      = (sat_mode_i == END_SAT) ? count_x : MIN_X;
                end else begin
                    next_x = count_x + STEP_X;
                end
            end
            MODE_DOWN: begin
                next_dir_o = DIR_DOWN;
                if (at_min) begin
                    end_event_o = 1'b1;
                    next_x      = (sat_mode_i == END_SAT) ? count_x : MAX_X;
                end else begin
                    next_x = count_x - STEP_X;
                end
            end
            MODE_BOUNCE: begin
                if (dir_i == DIR_UP) begin
                    if (at_max) begin
                        next_dir_o  = DIR_DOWN;
                        next_x      = BOUNCE_DN_X;
                        end_event_o = 1'b1;
                    end else begin
                        next_x = count_x + STEP_X;
                    end
                end else begin
                    if (at_min) begin
                        next_dir_o  = DIR_UP;
                        next_x      = BOUNCE_UP_X;
                        end_event_o = 1'b1;
                    end else begin
                        next_x = count_x - STEP_X;
                    end
                end
            end
            default: begin
                next_x      = count_x;
                next_dir_o  = dir_i;
                end_event_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/param_step_counter.sv
// Up/down/bounce counter over MIN_VAL, MIN_VAL+STEP, ..., MAX_VAL with wrap or saturate ends,
// normalising parallel load and a registered terminal-count pulse.
module param_step_counter
    import param_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int STEP    = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             count_en,
    input  logic [1:0]       c,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    localparam int EW        = WIDTH + 1;
    localparam int STEP_SAFE = (STEP < 1) ? 1 : STEP;
    localparam logic [WIDTH:0] MIN_X  = EW'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X  = EW'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_X = (MAX_VAL > MIN_VAL) ? EW'(STEP_SAFE) : EW'(1);

    generate
        if ((STEP < 1) || (MIN_VAL < 0) || (MIN_VAL > MAX_VAL) || (MAX_VAL >= (1 << WIDTH)) ||
            (((MAX_VAL - MIN_VAL) % STEP_SAFE) != 0)) begin : g_bad_params
            $fatal(1, "param_step_counter: illegal WIDTH/STEP/MIN_VAL/MAX_VAL combination");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    dir_state_e       dir_q, dir_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] step_count;
    logic             step_dir;
    logic             step_end;
    logic [WIDTH:0]   data_x;
    logic [WIDTH:0]   clamp_x;
    logic [WIDTH:0]   rem_x;
    logic [WIDTH-1:0] load_val;

    step_count_next #(
        .WIDTH   (WIDTH),
        .STEP    (STEP_SAFE),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count_i      (count_q),
        .dir_i        (dir_q),
        .c_i          (c),
        .sat_mode_i   (sat_mode),
        .next_count_o (step_count),
        .next_dir_o   (step_dir),
        .end_event_o  (step_end)
    );

    // Load normaliser: clamp into range, then round down onto the sequence grid.
    always_comb begin
        data_x = {1'b0, data_in};
        if (data_x < MIN_X) begin
            clamp_x = MIN_X;
        end else if (data_x > MAX_X) begin
            clamp_x = MAX_X;
        end else begin
            clamp_x = data_x;
        end
        rem_x    = (clamp_x - MIN_X) % STEP_X;
        load_val = WIDTH'(clamp_x - rem_x);
    end

    // Next-state selection: load beats counting; disabled or hold mode freezes state.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_val;
            dir_d   = ST_UP;
        end else if (count_en && (c != MODE_HOLD)) begin
            count_d = step_count;
            dir_d   = dir_state_e'(step_dir);
            tc_d    = step_end;
        end else begin
            count_d = count_q;
            dir_d   = dir_q;
        end
    end

    // State registers with asynchronous reset to the bottom of the sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= WIDTH'(MIN_VAL);
            dir_q   <= ST_UP;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign tc    = tc_q;

endmodule

// File: doc/param_step_counter.md
# param_step_counter

Parametrised up/down/bounce counter over an arithmetic sequence MIN_VAL, MIN_VAL+STEP, …, MAX_VAL, the general successor to the fixed 4-bit even-only counter. Each end of the sequence can wrap or saturate, and a bounce mode reverses direction at each end. The counter supports parallel load with value normalisation and a registered terminal-count pulse. It sits in the lab datapath as a reusable sequence and address generator driven by a controller FSM.

## Interface
- WIDTH, 4: count width in bits.
- STEP, 2: increment/decrement magnitude. Must be ≥ 1.
- MIN_VAL, 0: lowest legal count.
- MAX_VAL, 14: highest legal count. Elaboration-time checks: MIN_VAL ≤ MAX_VAL < 2^WIDTH, and (MAX_VAL−MIN_VAL) % STEP == 0. A violation is a fatal error.
- clk  in  1  posedge clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  parallel load enable.
- count_en  in  1  count enable.
- c  in  2  mode: 0 = up, 1 = down, 2 = bounce, 3 = hold.
- sat_mode  in  1  end behaviour for c=0 and c=1: 0 = wrap, 1 = saturate. Ignored in bounce mode.
- data_in  in  WIDTH  parallel load value; any value is accepted.
- count  out  WIDTH  current count. Always a legal sequence value.
- dir  out  1  current direction state: 0 = up, 1 = down.
- tc  out  1  registered one-cycle terminal-count pulse.

## Operation
- Priority: reset > load > count_en. If count_en=0 or c=3, count and dir hold and tc=0.
- Load normalisation is applied in this order:
  - clamp data_in to the range [MIN_VAL, MAX_VAL];
  - round down to MIN_VAL + floor((v−MIN_VAL)/STEP)·STEP.
- Load also sets dir=0 and tc=0.
- Up (c=0):
  - dir←0.
  - If count < MAX_VAL: count←count+STEP.
  - At MAX_VAL with wrap: count←MIN_VAL, tc←1.
  - At MAX_VAL with saturate: count holds, tc←1 on every enabled step attempted at MAX_VAL.
- Down (c=1): mirror of up. dir←1; at MIN_VAL, wrap gives count←MAX_VAL and saturate holds; tc←1 in both cases.
- Bounce (c=2):
  - dir=0 and count < MAX_VAL: count←count+STEP.
  - dir=0 and count == MAX_VAL: dir←1, count←MAX_VAL−STEP, tc←1.
  - dir=1: mirror of the above at MIN_VAL.
  - Entering bounce continues in the current dir.
- Degenerate MIN_VAL == MAX_VAL: count is constant. Every enabled step in modes 0–2 asserts tc. In bounce, dir still toggles.
- Arithmetic is done in WIDTH+1 bits. The end test is equality with MIN_VAL/MAX_VAL, which is sufficient because count is always aligned. No intermediate value may wrap modulo 2^WIDTH.
- Direction FSM has two states: UP (dir=0) and DOWN (dir=1).
  - Transitions happen on bounce reversal, on any enabled c=0/c=1 step (forces the state), or on load/reset (→UP).

## Timing
- All state updates on the posedge of clk. Load-to-count latency is 1 cycle; step-to-count latency is 1 cycle.
- tc is high for exactly the cycle following the edge that performed a wrap, a saturation attempt, or a reversal. It is never combinational from inputs.
- Reset values: count=MIN_VAL, dir=0, tc=0. Reset takes effect immediately and asynchronously, mid-count or mid-bounce. On release, the first active edge behaves normally.
- Changing c or sat_mode between cycles takes effect on the next edge. There is no pipeline state to flush.

## Structure
- Shared package param_counter_pkg holds:
  - mode constants (MODE_UP=2'd0, MODE_DOWN=2'd1, MODE_BOUNCE=2'd2, MODE_HOLD=2'd3);
  - end-behaviour constants (END_WRAP=1'b0, END_SAT=1'b1);
  - dir encoding (DIR_UP=1'b0, DIR_DOWN=1'b1).
- One natural sub-module, step_count_next. It is combinational and parametrised identically. From (count, dir, c, sat_mode) it produces next_count, next_dir, and end_event. The top-level adds the registers, the load normaliser, and the reset logic.

## Test plan
- Default params, sat_mode=0, c=0, 8 enabled steps from reset → count 2,4,…,14,0. tc high only in the cycle count first reads 0.
- Default params, c=1, sat_mode=1, from 2 → 0, 0, 0. tc high in each cycle after a step attempted at 0.
- STEP=3, MIN_VAL=2, MAX_VAL=14. Loading data_in 9, 15, 0 in turn produces count 8, 14, 2, each 1 cycle after the load. dir=0 after each load.
- Default params, c=2 from 10 → 12, 14, 12, 10. dir goes to 1 on the edge producing 12 after 14; tc pulses once.
- Assert load and count_en together with data_in=7 → count=6, no step taken. Assert reset asynchronously mid-bounce → count=0, dir=0, tc=0 before the next edge.
- MIN_VAL=MAX_VAL=5, c=2, 3 enabled steps → count stays 5, tc high each cycle, dir toggles 1, 0, 1.
